// File: rtl/axis_ptt_sequencer.sv
// axis_ptt_sequencer: keys the radio, opens the AXIS PTT gate for one frame,
// then holds a key-down tail and an unkeyed holdoff before the next frame.
module axis_ptt_sequencer #(
    parameter int CNT_WIDTH      = 24,
    parameter int KEYUP_CYCLES   = 1000,
    parameter int TAIL_CYCLES    = 500,
    parameter int HOLDOFF_CYCLES = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       tx_req,
    input  logic       tx_abort,
    input  logic       mon_tvalid,
    input  logic       mon_tready,
    input  logic       mon_tlast,
    output logic       radio_ptt,
    output logic       ptt_en,
    output logic       busy,
    output logic       tx_done,
    output logic       timeout_err,
    output logic       aborted,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEYUP   = 3'd1,
        ACTIVE  = 3'd2,
        TAIL    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // Each phase loads (length - 1) and leaves when the down-counter reads zero.
    localparam logic [CNT_WIDTH-1:0] KEYUP_LD = CNT_WIDTH'(KEYUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TAIL_LD  = CNT_WIDTH'(TAIL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LD  = CNT_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LD    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ptt_q, en_q, busy_q, done_q, terr_q, abt_q;
    logic                 done_d, terr_d, abt_d;
    logic                 beat, cnt_zero;

    assign beat     = mon_tvalid & mon_tready & mon_tlast;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_WIDTH'(1);
        terr_d  = terr_q;
        abt_d   = abt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (tx_req && !tx_abort) begin
                state_d = KEYUP;
                cnt_d   = KEYUP_LD;
                terr_d  = 1'b0;
                abt_d   = 1'b0;
            end
            KEYUP: if (tx_abort) begin
                state_d = HOLDOFF;
                cnt_d   = HOLD_LD;
                abt_d   = 1'b1;
            end else if (cnt_zero) begin
                state_d = ACTIVE;
                cnt_d   = TO_LD;
            end
            // A completed frame wins over abort, abort wins over timeout.
            ACTIVE: if (beat || tx_abort || cnt_zero) begin
                state_d = TAIL;
                cnt_d   = TAIL_LD;
                abt_d   = abt_q | (!beat && tx_abort);
                terr_d  = terr_q | (!beat && !tx_abort);
            end
            TAIL: if (cnt_zero) begin
                state_d = HOLDOFF;
                cnt_d   = HOLD_LD;
            end
            HOLDOFF: if (cnt_zero) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptt_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptt_q   <= state_d inside {KEYUP, ACTIVE, TAIL};
            en_q    <= state_d == ACTIVE;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
            terr_q  <= terr_d;
            abt_q   <= abt_d;
        end
    end

    assign radio_ptt   = ptt_q;
    assign ptt_en      = en_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign timeout_err = terr_q;
    assign aborted     = abt_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_axis_ptt_sequencer.sv
// tb_axis_ptt_sequencer: scoreboard bench; a phase-timeline model predicts every
// cycle's outputs and a separate monitor compares them against the sequencer.
module tb_axis_ptt_sequencer;
    localparam int K = 4, T = 3, H = 2, TO = 20;

    logic aclk = 0, aresetn = 0, tx_req = 0, tx_abort = 0;
    logic mon_tvalid = 0, mon_tready = 0, mon_tlast = 0;
    logic radio_ptt, ptt_en, busy, tx_done, timeout_err, aborted;
    logic [2:0] state_o;

    int tests = 0, fails = 0;
    logic [8:0] expq[$];
    logic [8:0] x;
    int m = 0, e = 0;
    logic mterr = 0, mabt = 0, mdone = 0;
    bit exact = 0, keyed = 0;
    int low_run = 0;

    axis_ptt_sequencer #(
        .CNT_WIDTH(24), .KEYUP_CYCLES(K), .TAIL_CYCLES(T),
        .HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .tx_req(tx_req), .tx_abort(tx_abort),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .radio_ptt(radio_ptt), .ptt_en(ptt_en), .busy(busy), .tx_done(tx_done),
        .timeout_err(timeout_err), .aborted(aborted), .state_o(state_o)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic key();
        tx_req = 1;
        cyc(1);
        tx_req = 0;
    endtask

    // Reference: phase m (0 idle,1 keyup,2 active,3 tail,4 holdoff), e = cycles spent in phase.
    always @(posedge aclk) begin
        mdone = 0;
        if (!aresetn) begin
            m = 0; e = 0; mterr = 0; mabt = 0;
        end else begin
            case (m)
                0: if (tx_req && !tx_abort) begin m = 1; e = 1; mterr = 0; mabt = 0; end
                1: if (tx_abort) begin m = 4; e = 1; mabt = 1; end
                   else if (e == K) begin m = 2; e = 1; end
                   else e++;
                2: if (mon_tvalid && mon_tready && mon_tlast) begin m = 3; e = 1; end
                   else if (tx_abort) begin m = 3; e = 1; mabt = 1; end
                   else if (e == TO) begin m = 3; e = 1; mterr = 1; end
                   else e++;
                3: if (e == T) begin m = 4; e = 1; end else e++;
                default: if (e == H) begin m = 0; e = 0; mdone = 1; end else e++;
            endcase
            expq.push_back({m >= 1 && m <= 3, m == 2, m != 0, mdone, mterr, mabt, 3'(m)});
        end
    end

    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            keyed = 0;
            low_run = 0;
        end else if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("outputs", {radio_ptt, ptt_en, busy, tx_done, timeout_err, aborted, state_o}, x);
            if (!radio_ptt) low_run++;
            else begin
                if (keyed && low_run > 0) begin
                    if (exact) chk("ptt_low_exact", low_run, H + 1);
                    else chk("ptt_low_min", low_run >= H + 1, 1);
                end
                keyed = 1;
                low_run = 0;
            end
            if (ptt_en) chk("en_implies_ptt", radio_ptt, 1);
        end
    end

    initial begin
        #2;
        chk("rst_ptt", radio_ptt, 0);
        chk("rst_en", ptt_en, 0);
        chk("rst_state", state_o, 0);
        cyc(3);
        aresetn = 1;
        cyc(2);
        // Single frame closed by a tlast beat.
        key();
        cyc(9);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b111;
        cyc(1);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
        cyc(15);
        // Stalled tlast never closes; timeout does, then clears on next keying.
        key();
        cyc(3);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b101;
        cyc(30);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
        cyc(5);
        key();
        cyc(8);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b111;
        cyc(1);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
        cyc(12);
        // Abort during key-up.
        key();
        cyc(1);
        tx_abort = 1;
        cyc(1);
        tx_abort = 0;
        cyc(10);
        // Beat and abort on the same edge: completion wins.
        key();
        cyc(5);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b111;
        tx_abort = 1;
        cyc(1);
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
        tx_abort = 0;
        cyc(12);
        // Back-to-back keying with tx_req held.
        tx_req = 1;
        {mon_tvalid, mon_tready, mon_tlast} = 3'b111;
        cyc(3);
        exact = 1;
        cyc(60);
        exact = 0;
        tx_req = 0;
        {mon_tvalid, mon_tready, mon_tlast} = 3'b000;
        cyc(15);
        // Randomized traffic.
        repeat (3000) begin
            tx_req     = ($urandom_range(3) == 0);
            tx_abort   = ($urandom_range(40) == 0);
            mon_tvalid = 1'($urandom_range(1));
            mon_tready = 1'($urandom_range(1));
            mon_tlast  = ($urandom_range(5) == 0);
            cyc(1);
        end
        {tx_req, tx_abort, mon_tvalid, mon_tready, mon_tlast} = 5'b0;
        cyc(40);
        // Asynchronous reset in ACTIVE.
        key();
        cyc(6);
        chk("pre_rst_en", ptt_en, 1);
        aresetn = 0;
        #1;
        chk("arst_ptt", radio_ptt, 0);
        chk("arst_en", ptt_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_state", state_o, 0);
        cyc(2);
        aresetn = 1;
        cyc(6);
        chk("post_rst_idle", busy, 0);
        key();
        cyc(35);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
